// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO that captures committed ALU result/zero pairs
// so a slow consumer can drain them independently of the pipeline clocking.
module alu_result_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Clear,
    input  logic         Push,
    input  logic [N-1:0] ALUresult,
    input  logic         Zero,
    input  logic         Pop,
    output logic [N-1:0] Dout,
    output logic         DoutZero,
    output logic         Empty,
    output logic         Full,
    output logic [AW:0]  Count,
    output logic         Overflow
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [N:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    always_comb begin
        do_pop  = Pop && (Count != '0) && !Clear;
        do_push = Push && ((Count < DEPTH_CNT) || do_pop) && !Clear;
        drop    = Push && !do_push && !Clear;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else if (Clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      Count <= Count + 1'b1;
            else if (do_pop && !do_push) Count <= Count - 1'b1;
            if (drop) Overflow <= 1'b1;
        end
    end

    // Storage is intentionally not reset; Count gates what is visible.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= {Zero, ALUresult};
    end

    always_comb begin
        Empty = (Count == '0);
        Full  = (Count == DEPTH_CNT);
        if (Count != '0) begin
            Dout     = mem[rd_ptr][N-1:0];
            DoutZero = mem[rd_ptr][N];
        end else begin
            Dout     = '0;
            DoutZero = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: expected entries are queued on push
// and compared against Dout as the FIFO is drained.
module tb_alu_result_fifo;

    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Clear;
    logic         Push;
    logic [N-1:0] ALUresult;
    logic         Zero;
    logic         Pop;
    logic [N-1:0] Dout;
    logic         DoutZero;
    logic         Empty;
    logic         Full;
    logic [AW:0]  Count;
    logic         Overflow;

    int checks = 0;
    int errors = 0;

    logic [N:0] sb_q[$];
    logic       m_ovf;

    alu_result_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .Rst(Rst), .Clear(Clear), .Push(Push), .ALUresult(ALUresult),
        .Zero(Zero), .Pop(Pop), .Dout(Dout), .DoutZero(DoutZero), .Empty(Empty),
        .Full(Full), .Count(Count), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [N:0] head;
        head = (sb_q.size() != 0) ? sb_q[0] : '0;
        check({tag, ".count"}, 64'(Count), 64'(sb_q.size()));
        check({tag, ".empty"}, 64'(Empty), 64'(sb_q.size() == 0));
        check({tag, ".full"}, 64'(Full), 64'(sb_q.size() == DEPTH));
        check({tag, ".ovf"}, 64'(Overflow), 64'(m_ovf));
        check({tag, ".dout"}, 64'(Dout), 64'(head[N-1:0]));
        check({tag, ".dzero"}, 64'(DoutZero), 64'(head[N]));
    endtask

    // One clock: inputs driven after the edge, model updated, state checked after the edge.
    task automatic step(input logic push, input logic [N-1:0] data, input logic zero,
                        input logic pop, input logic clr, input string tag);
        logic acc_pop, acc_push;
        Push = push; ALUresult = data; Zero = zero; Pop = pop; Clear = clr;
        @(negedge Clk);
        if (clr) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            acc_pop  = pop && (sb_q.size() != 0);
            acc_push = push && ((sb_q.size() < DEPTH) || acc_pop);
            if (acc_pop) begin
                check({tag, ".pop_data"}, 64'(Dout), 64'(sb_q[0][N-1:0]));
                check({tag, ".pop_zero"}, 64'(DoutZero), 64'(sb_q[0][N]));
                void'(sb_q.pop_front());
            end
            if (acc_push) sb_q.push_back({zero, data});
            else if (push) m_ovf = 1'b1;
        end
        @(posedge Clk);
        #1;
        Push = 1'b0; Pop = 1'b0; Clear = 1'b0;
        check_state(tag);
    endtask

    initial begin
        Rst = 1'b0; Clear = 1'b0; Push = 1'b0; Pop = 1'b0; ALUresult = '0; Zero = 1'b0;
        m_ovf = 1'b0;
        #1;
        check_state("reset");
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_state("idle");

        // basic push/pop and zero flag
        step(1, 32'h5, 0, 0, 0, "push5");
        step(1, 32'h0, 1, 0, 0, "push0");
        step(0, '0, 0, 1, 0, "pop1");
        step(0, '0, 0, 1, 0, "pop2");
        step(0, '0, 0, 1, 0, "pop_empty");
        step(1, 32'h77, 0, 1, 0, "pushpop_empty");
        step(0, '0, 0, 1, 0, "drain77");

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step(1, 32'h10 + i, i[0], 0, 0, "fill");
        step(1, 32'hFF, 0, 0, 0, "ovf_push");
        for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 0, "drain");
        check("ovf_sticky", 64'(Overflow), 64'd1);

        // simultaneous push/pop when full
        step(0, '0, 0, 0, 1, "clear1");
        for (int i = 0; i < DEPTH; i++) step(1, 32'h10 + i, 0, 0, 0, "fill2");
        step(1, 32'hAA, 0, 1, 0, "full_pushpop");
        check("head_after", 64'(Dout), 64'h11);
        for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 0, "drain2");

        // pointer wrap with 3 entries resident
        for (int i = 0; i < 3; i++) step(1, 32'd100 + i, 0, 0, 0, "preload");
        for (int i = 0; i < 20; i++) step(1, 32'd103 + i, 0, 1, 0, "wrap");
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, "wrap_drain");

        // Clear beats Push with Overflow set and 5 entries held
        for (int i = 0; i < DEPTH; i++) step(1, 32'h200 + i, 0, 0, 0, "fill3");
        step(1, 32'hDEAD, 0, 0, 0, "ovf2");
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, "to5");
        check("cnt5", 64'(Count), 64'd5);
        step(1, 32'hBEEF, 1, 0, 1, "clear_push");

        // asynchronous reset mid-push
        step(1, 32'h31, 0, 0, 0, "pre_rst");
        step(1, 32'h32, 0, 0, 0, "pre_rst2");
        Push = 1'b1; ALUresult = 32'h33;
        #2 Rst = 1'b0;
        #1;
        sb_q.delete();
        m_ovf = 1'b0;
        check_state("async_rst");
        Push = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check_state("post_rst");
        step(1, 32'h44, 1, 0, 0, "after_rst_push");
        step(0, '0, 0, 1, 0, "after_rst_pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
